// File: rtl/halt_drain_dump.sv
// rtl/halt_drain_dump.sv - halt detect, pipeline drain and data-memory dump streamer
// Optional checksum beat after the last word is enabled by defining DUMP_CHECKSUM_EN.
module halt_drain_dump #(
  parameter int          DRAIN_CYCLES = 4,
  parameter int          MEM_WORDS    = 512,
  parameter logic [31:0] HALT_WORD    = 32'hFFFF_FFFF
) (
  input  logic        CLOCK,
  input  logic        RESET,
  input  logic [31:0] inst_f,
  input  logic        inst_valid,
  output logic        cpu_freeze,
  output logic [8:0]  mem_rd_addr,
  input  logic [31:0] mem_rd_data,
  output logic        dump_valid,
  input  logic        dump_ready,
  output logic [31:0] dump_data,
  output logic [8:0]  dump_addr,
  output logic        dump_last,
  output logic        done
);

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_DUMP  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);
  localparam logic [9:0] LAST_WORD  = 10'(MEM_WORDS - 1);
`ifdef DUMP_CHECKSUM_EN
  localparam logic [9:0] LAST_BEAT  = 10'(MEM_WORDS);
`else
  localparam logic [9:0] LAST_BEAT  = LAST_WORD;
`endif

  logic [1:0]  state_q, state_d;
  logic [3:0]  drain_cnt_q, drain_cnt_d;
  logic [9:0]  addr_cnt_q, addr_cnt_d;
  logic        valid_q, valid_d;
  logic        last_q, last_d;
  logic [31:0] data_q, data_d;
  logic [8:0]  daddr_q, daddr_d;
`ifdef DUMP_CHECKSUM_EN
  logic [31:0] xsum_q, xsum_d;
`endif

  logic halt_det;
  logic beat_accept;
  logic issue;

  // A halt word coinciding with RESET is ignored so it cannot survive reset.
  assign halt_det    = !RESET && inst_valid && (inst_f == HALT_WORD) && (state_q == S_RUN);
  assign cpu_freeze  = (state_q != S_RUN) || halt_det;
  assign mem_rd_addr = (state_q == S_DUMP) ? addr_cnt_q[8:0] : 9'd0;
  assign beat_accept = valid_q && dump_ready;
  assign issue       = (state_q == S_DUMP) && (addr_cnt_q <= LAST_BEAT) && (!valid_q || dump_ready);

  assign dump_valid = valid_q;
  assign dump_data  = data_q;
  assign dump_addr  = daddr_q;
  assign dump_last  = last_q;
  assign done       = (state_q == S_DONE);

  always_comb begin
    state_d     = state_q;
    drain_cnt_d = drain_cnt_q;
    addr_cnt_d  = addr_cnt_q;
    valid_d     = valid_q;
    last_d      = last_q;
    data_d      = data_q;
    daddr_d     = daddr_q;
`ifdef DUMP_CHECKSUM_EN
    xsum_d      = xsum_q;
`endif
    case (state_q)
      S_RUN: begin
        if (halt_det) begin
          drain_cnt_d = DRAIN_LOAD;
          addr_cnt_d  = 10'd0;
          state_d     = (DRAIN_LOAD == 4'd0) ? S_DUMP : S_DRAIN;
        end
      end
      S_DRAIN: begin
        // Leaving as the counter reaches zero makes halt-to-DUMP exactly DRAIN_CYCLES.
        drain_cnt_d = drain_cnt_q - 4'd1;
        addr_cnt_d  = 10'd0;
        if (drain_cnt_q <= 4'd1) begin
          drain_cnt_d = 4'd0;
          state_d     = S_DUMP;
        end
      end
      S_DUMP: begin
        if (beat_accept && last_q) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          state_d = S_DONE;
        end else if (issue) begin
          valid_d    = 1'b1;
          last_d     = (addr_cnt_q == LAST_BEAT);
          addr_cnt_d = addr_cnt_q + 10'd1;
`ifdef DUMP_CHECKSUM_EN
          if (addr_cnt_q == LAST_BEAT) begin
            data_d  = xsum_q;
            daddr_d = 9'h1FF;
          end else begin
            data_d  = mem_rd_data;
            daddr_d = addr_cnt_q[8:0];
            xsum_d  = xsum_q ^ mem_rd_data;
          end
`else
          data_d  = mem_rd_data;
          daddr_d = addr_cnt_q[8:0];
`endif
        end else if (beat_accept) begin
          valid_d = 1'b0;
        end
      end
      S_DONE: begin
        state_d = S_DONE;
      end
      default: begin
        state_d = S_RUN;
      end
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      state_q     <= S_RUN;
      drain_cnt_q <= 4'd0;
      addr_cnt_q  <= 10'd0;
      valid_q     <= 1'b0;
      last_q      <= 1'b0;
      data_q      <= 32'd0;
      daddr_q     <= 9'd0;
`ifdef DUMP_CHECKSUM_EN
      xsum_q      <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      drain_cnt_q <= drain_cnt_d;
      addr_cnt_q  <= addr_cnt_d;
      valid_q     <= valid_d;
      last_q      <= last_d;
      data_q      <= data_d;
      daddr_q     <= daddr_d;
`ifdef DUMP_CHECKSUM_EN
      xsum_q      <= xsum_d;
`endif
    end
  end

endmodule

// File: tb/tb_halt_drain_dump.sv
// tb/tb_halt_drain_dump.sv - directed bench for halt_drain_dump (MEM_WORDS=4, DRAIN_CYCLES=4)
module tb_halt_drain_dump;

  localparam int          MW = 4;
  localparam int          DC = 4;
  localparam logic [31:0] HW = 32'hFFFF_FFFF;
`ifdef DUMP_CHECKSUM_EN
  localparam int          NB = MW + 1;
`else
  localparam int          NB = MW;
`endif

  logic        CLOCK = 1'b0;
  logic        RESET = 1'b1;
  logic [31:0] inst_f = 32'd0;
  logic        inst_valid = 1'b0;
  logic        cpu_freeze;
  logic [8:0]  mem_rd_addr;
  logic [31:0] mem_rd_data;
  logic        dump_valid;
  logic        dump_ready = 1'b1;
  logic [31:0] dump_data;
  logic [8:0]  dump_addr;
  logic        dump_last;
  logic        done;

  logic [31:0] mem [0:511];
  int total = 0;
  int passed = 0;
  int fails = 0;

  assign mem_rd_data = mem[mem_rd_addr];

  always #5 CLOCK = ~CLOCK;

  halt_drain_dump #(
    .DRAIN_CYCLES(DC),
    .MEM_WORDS(MW),
    .HALT_WORD(HW)
  ) dut (
    .CLOCK(CLOCK),
    .RESET(RESET),
    .inst_f(inst_f),
    .inst_valid(inst_valid),
    .cpu_freeze(cpu_freeze),
    .mem_rd_addr(mem_rd_addr),
    .mem_rd_data(mem_rd_data),
    .dump_valid(dump_valid),
    .dump_ready(dump_ready),
    .dump_data(dump_data),
    .dump_addr(dump_addr),
    .dump_last(dump_last),
    .done(done)
  );

  task automatic tick;
    @(posedge CLOCK);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk9(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_data(input int b);
    logic [31:0] x;
    x = 32'd0;
    if (b < MW) return mem[b];
    for (int i = 0; i < MW; i++) x = x ^ mem[i];
    return x;
  endfunction

  function automatic logic [8:0] exp_addr(input int b);
    if (b < MW) return 9'(b);
    return 9'h1FF;
  endfunction

  // Called in the halt cycle; returns in the cycle where the first beat must show.
  task automatic halt_and_drain(input logic second_halt);
    inst_f = HW;
    inst_valid = 1'b1;
    #1;
    chk1("freeze_on_halt", cpu_freeze, 1'b1);
    chk1("valid_in_halt_cycle", dump_valid, 1'b0);
    tick;
    for (int i = 1; i < DC; i++) begin
      if (second_halt && i == 2) begin
        inst_f = HW;
        inst_valid = 1'b1;
      end else begin
        inst_f = 32'h0000_0013;
        inst_valid = 1'b0;
      end
      #1;
      chk1("freeze_drain", cpu_freeze, 1'b1);
      chk1("valid_drain", dump_valid, 1'b0);
      chk1("done_drain", done, 1'b0);
      tick;
    end
    inst_f = 32'h0000_0013;
    inst_valid = 1'b0;
    #1;
    chk1("valid_dump_entry", dump_valid, 1'b0);
    chk9("rd_addr_dump_entry", mem_rd_addr, 9'd0);
    tick;
  endtask

  task automatic dump_run(input logic [31:0] rdy_pat);
    int b;
    b = 0;
    for (int c = 0; c < 32 && b < NB; c++) begin
      dump_ready = rdy_pat[c];
      #1;
      chk1("beat_valid", dump_valid, 1'b1);
      chk32("beat_data", dump_data, exp_data(b));
      chk9("beat_addr", dump_addr, exp_addr(b));
      chk1("beat_last", dump_last, (b == NB - 1));
      chk1("freeze_dump", cpu_freeze, 1'b1);
      if (b + 1 < MW) chk9("rd_addr_dump", mem_rd_addr, 9'(b + 1));
      if (dump_ready) b++;
      tick;
    end
    dump_ready = 1'b1;
    #1;
    chk1("valid_after_last", dump_valid, 1'b0);
    chk1("done_after_last", done, 1'b1);
    chk1("freeze_done", cpu_freeze, 1'b1);
  endtask

  initial begin
    for (int i = 0; i < 512; i++) mem[i] = 32'(i + 1);

    // Reset with a live halt word on the fetch bus.
    RESET = 1'b1;
    inst_f = HW;
    inst_valid = 1'b1;
    tick;
    tick;
    RESET = 1'b0;
    inst_valid = 1'b0;
    inst_f = 32'd0;
    #1;
    chk1("rst_valid", dump_valid, 1'b0);
    chk1("rst_last", dump_last, 1'b0);
    chk1("rst_done", done, 1'b0);
    chk32("rst_data", dump_data, 32'd0);
    chk9("rst_addr", dump_addr, 9'd0);
    chk1("rst_freeze", cpu_freeze, 1'b0);
    chk9("rst_rd_addr", mem_rd_addr, 9'd0);

    // Halt encoding without inst_valid must be ignored.
    tick;
    inst_f = HW;
    inst_valid = 1'b0;
    #1;
    chk1("invalid_halt_freeze", cpu_freeze, 1'b0);
    tick;
    inst_f = 32'd0;
    #1;
    chk1("invalid_halt_freeze_next", cpu_freeze, 1'b0);
    chk1("invalid_halt_valid_next", dump_valid, 1'b0);
    repeat (3) tick;

    // Basic dump, ready always high.
    halt_and_drain(1'b0);
    dump_run(32'hFFFF_FFFF);

    // DONE is sticky and ignores further halts.
    inst_f = HW;
    inst_valid = 1'b1;
    repeat (3) tick;
    chk1("done_hold", done, 1'b1);
    chk1("done_hold_freeze", cpu_freeze, 1'b1);
    chk1("done_hold_valid", dump_valid, 1'b0);
    inst_valid = 1'b0;

    // Backpressure on addr 2 for three cycles, second halt during drain.
    RESET = 1'b1;
    tick;
    RESET = 1'b0;
    #1;
    chk1("rst2_done", done, 1'b0);
    chk1("rst2_freeze", cpu_freeze, 1'b0);
    tick;
    halt_and_drain(1'b1);
    dump_run(32'hFFFF_FFE3);

    // Reset while the second beat is presented aborts the dump.
    RESET = 1'b1;
    tick;
    RESET = 1'b0;
    tick;
    halt_and_drain(1'b0);
    dump_ready = 1'b1;
    #1;
    chk9("abort_beat0_addr", dump_addr, 9'd0);
    tick;
    RESET = 1'b1;
    #1;
    chk1("abort_beat1_valid", dump_valid, 1'b1);
    chk32("abort_beat1_data", dump_data, 32'd2);
    tick;
    RESET = 1'b0;
    #1;
    chk1("abort_valid", dump_valid, 1'b0);
    chk1("abort_freeze", cpu_freeze, 1'b0);
    chk1("abort_done", done, 1'b0);
    chk9("abort_addr", dump_addr, 9'd0);
    chk32("abort_data", dump_data, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick;
      chk1("abort_quiet", dump_valid, 1'b0);
    end

    // Restart with a fresh memory image; the dump begins again at addr 0.
    mem[0] = 32'hDEAD_BEEF;
    mem[1] = 32'h0000_0000;
    mem[2] = 32'h1234_5678;
    mem[3] = 32'hFFFF_FFFF;
    tick;
    halt_and_drain(1'b0);
    dump_run(32'hFFFF_FFFF);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/halt_drain_dump.md
HALT_DRAIN_DUMP -- requirements
Module: halt_drain_dump

Interface
REQ-001 The block SHALL have parameter DRAIN_CYCLES, default 4: cycles between halt detection and dump start, allowing in-flight instructions to reach write-back; legal range 1..15.
REQ-002 The block SHALL have parameter MEM_WORDS, default 512: number of 32-bit data-memory words dumped; legal range 1..512.
REQ-003 The block SHALL have parameter HALT_WORD, default 32'hFFFF_FFFF: instruction encoding that terminates execution.
REQ-004 The block SHALL have port CLOCK, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port RESET, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port inst_f, input, 32 bits: instruction currently fetched by the CPU.
REQ-007 The block SHALL have port inst_valid, input, 1 bit: inst_f is a real fetch (not stalled or flushed).
REQ-008 The block SHALL have port cpu_freeze, output, 1 bit: holds the PC and IF/ID and blocks memory writes from the dump side.
REQ-009 The block SHALL have port mem_rd_addr, output, 9 bits: data-memory word address driven during the dump.
REQ-010 The block SHALL have port mem_rd_data, input, 32 bits: combinational read data for mem_rd_addr.
REQ-011 The block SHALL have port dump_valid, output, 1 bit: a dump beat is presented.
REQ-012 The block SHALL have port dump_ready, input, 1 bit: the consumer accepts the beat.
REQ-013 The block SHALL have port dump_data, output, 32 bits: beat payload.
REQ-014 The block SHALL have port dump_addr, output, 9 bits: word address of the beat.
REQ-015 The block SHALL have port dump_last, output, 1 bit: final beat of the dump.
REQ-016 The block SHALL have port done, output, 1 bit: the dump is complete and the block is idle.

Function
REQ-017 The FSM SHALL have states RUN, DRAIN, DUMP and DONE.
REQ-018 In RUN, when inst_valid=1 and inst_f==HALT_WORD, the FSM SHALL go to DRAIN and load the drain counter with DRAIN_CYCLES-1.
REQ-019 cpu_freeze SHALL be combinational: 1 in the halt-detect cycle in RUN and in every state other than RUN, so the PC never advances past the halt word.
REQ-020 In DRAIN, the counter SHALL decrement each cycle; at 0 the FSM SHALL go to DUMP with the address counter at 0, so the total halt-to-DUMP time is exactly DRAIN_CYCLES cycles.
REQ-021 In DUMP, mem_rd_addr SHALL equal the address counter; outside DUMP it SHALL be 0.
REQ-022 A beat is loaded when dump_valid=0, or when dump_valid=1 and dump_ready=1; on load, dump_data<=mem_rd_data, dump_addr<=counter, dump_valid<=1, and the counter increments.
REQ-023 The first dump_valid SHALL rise 1 cycle after entering DUMP; with dump_ready held at 1, throughput SHALL be one beat per cycle.
REQ-024 While dump_valid=1 and dump_ready=0, dump_data, dump_addr and dump_last SHALL be held stable.
REQ-025 dump_last SHALL be 1 only on the final beat; when the final beat is accepted, dump_valid SHALL drop and the FSM SHALL go to DONE.
REQ-026 Address wrap SHALL NOT occur; the counter stops issuing loads after MEM_WORDS-1.
REQ-027 In DONE, done=1 and cpu_freeze=1 SHALL hold until RESET.
REQ-028 Halt words seen in DRAIN, DUMP or DONE SHALL be ignored.
REQ-029 The block SHALL never assert dump_valid outside DUMP.

Reset
REQ-030 On RESET=1 at a clock edge: state<=RUN, counters<=0, dump_valid=0, dump_last=0, done=0, dump_data=0, dump_addr=0.
REQ-031 RESET SHALL take priority in any state; an in-progress dump is aborted and no further beats are issued.
REQ-032 A halt word present in the reset cycle SHALL NOT be detected.

Configuration
REQ-033 When DUMP_CHECKSUM_EN is defined, the block SHALL issue one extra beat after word MEM_WORDS-1 with dump_data equal to the XOR of all dumped words and dump_addr=9'h1FF; dump_last SHALL move to that beat.
REQ-034 When DUMP_CHECKSUM_EN is undefined, the block SHALL have no checksum logic, and dump_last SHALL mark word MEM_WORDS-1.

Verification
REQ-035 With MEM_WORDS=4, DRAIN_CYCLES=4, memory {1,2,3,4}, dump_ready=1, halt at cycle 10: expect cpu_freeze=1 from cycle 10, DUMP entered at cycle 14, beats 1,2,3,4 on cycles 15-18 with dump_last on 4, and done=1 at cycle 19.
REQ-036 Same setup with dump_ready low for 3 cycles on beat addr 2: expect data 3 held for 3 cycles and no beat lost or duplicated.
REQ-037 Same setup with DUMP_CHECKSUM_EN defined: expect a fifth beat with data 32'h4 and addr 9'h1FF carrying dump_last.
REQ-038 Assert RESET during beat 2: expect dump_valid=0 and state RUN next cycle; a new halt restarts the dump from addr 0.
REQ-039 Present HALT_WORD with inst_valid=0: expect no transition and cpu_freeze=0; present a second halt in DRAIN: expect timing unchanged.
